// File: rtl/yuyv_block_sched.sv
// -----------------------------------------------------------------------------
// yuyv_block_sched
//
// Paces the transfer of 8x8 YUV blocks from the YUYV converter FIFO into the
// JPEG encoder for one captured frame. After a frame is announced, the block
// requests the frame from the converter. For each block the converter reports
// as fetched, it waits a fixed settling delay and then for the encoder to be
// free. It then reads the whole block out of the FIFO as one uninterrupted
// burst.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   frame_rdy  in   1-cycle pulse: a captured frame is in memory
//   img_req    out  frame request to the converter (held 2 cycles)
//   blk_ready  in   1-cycle pulse per block the converter has fetched
//   enc_busy   in   encoder cannot accept a new block
//   je_rd      out  converter FIFO read strobe
//   enc_load   out  je_rd delayed one cycle (FIFO read data valid)
//   blk_start  out  high on the first je_rd of every block
//   blk_idx    out  raster index of the current block
//   frame_done out  1-cycle pulse after the last block has been read
//   busy       out  scheduler is not idle
//   err        out  sticky: pending-block overflow or frame_rdy while busy
// -----------------------------------------------------------------------------
module yuyv_block_sched #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 200,
  parameter int BLK_BYTES = 192,
  parameter int DRAIN_DLY = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_rdy,
  output logic       img_req,
  input  logic       blk_ready,
  input  logic       enc_busy,
  output logic       je_rd,
  output logic       enc_load,
  output logic       blk_start,
  output logic [9:0] blk_idx,
  output logic       frame_done,
  output logic       busy,
  output logic       err
);

  localparam int         NBLK      = (WIDTH / 8) * (HEIGHT / 8);
  localparam logic [9:0] LAST_IDX  = 10'(NBLK - 1);
  localparam logic [7:0] LAST_BYTE = 8'(BLK_BYTES - 1);
  localparam logic [15:0] LAST_DLY = 16'(DRAIN_DLY - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_BLK = 3'd2,
    DRAIN    = 3'd3,
    WAIT_ENC = 3'd4,
    READ     = 3'd5,
    NEXT     = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        req_cnt;
  logic [15:0] dly_cnt;
  logic [7:0]  byte_cnt;
  logic [1:0]  pend;
  logic [9:0]  idx_q;
  logic        err_q;
  logic        rd_p1;

  logic        pend_inc;
  logic        pend_dec;
  logic        pend_ovf;

  // Saturating update of the pending-block count. A simultaneous arrival and
  // consumption cancel out; an arrival at the ceiling is clamped (the caller
  // flags it as an overflow).
  function automatic logic [1:0] pend_upd(input logic [1:0] p,
                                          input logic       inc,
                                          input logic       dec);
    logic [1:0] r;
    r = p;
    if (inc && !dec) begin
      r = (p == 2'd3) ? p : p + 2'd1;
    end else if (dec && !inc) begin
      r = (p == 2'd0) ? p : p - 2'd1;
    end
    return r;
  endfunction

  // Block arrivals are only counted once a frame is in progress; a block is
  // consumed at the moment the burst read is committed.
  assign pend_inc = blk_ready && (state_q != IDLE);
  assign pend_dec = (state_q == WAIT_ENC) && (state_d == READ);
  assign pend_ovf = pend_inc && !pend_dec && (pend == 2'd3);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (frame_rdy) state_d = REQ;
      end
      REQ: begin
        // Converter edge-detects img_req, so it is held for two cycles.
        if (req_cnt) state_d = WAIT_BLK;
      end
      WAIT_BLK: begin
        // A blk_ready arriving in this very cycle counts as pending, so the
        // drain delay starts one cycle earlier than waiting for the counter.
        if ((pend != 2'd0) || blk_ready) state_d = DRAIN;
      end
      DRAIN: begin
        if (dly_cnt == LAST_DLY) state_d = WAIT_ENC;
      end
      WAIT_ENC: begin
        if (!enc_busy) state_d = READ;
      end
      READ: begin
        // Once started, the burst runs to completion whatever enc_busy does.
        if (byte_cnt == LAST_BYTE) state_d = NEXT;
      end
      NEXT: begin
        state_d = (idx_q == LAST_IDX) ? DONE : WAIT_BLK;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_cnt  <= 1'b0;
      dly_cnt  <= '0;
      byte_cnt <= '0;
      pend     <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_cnt  <= (state_q == REQ) && (state_d == REQ);
      dly_cnt  <= ((state_q == DRAIN) && (state_d == DRAIN)) ? dly_cnt + 16'd1 : '0;
      byte_cnt <= ((state_q == READ) && (state_d == READ)) ? byte_cnt + 8'd1 : '0;

      if (state_q == IDLE) begin
        pend <= '0;
      end else begin
        pend <= pend_upd(pend, pend_inc, pend_dec);
      end

      if ((state_q == IDLE) && frame_rdy) begin
        idx_q <= '0;
      end else if ((state_q == NEXT) && (state_d == WAIT_BLK)) begin
        idx_q <= idx_q + 10'd1;
      end

      if (pend_ovf || (frame_rdy && (state_q != IDLE))) begin
        err_q <= 1'b1;
      end
    end
  end

  // Stage p1: FIFO read data is valid one cycle after the strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_p1 <= 1'b0;
    end else begin
      rd_p1 <= je_rd;
    end
  end

  assign img_req    = (state_q == REQ);
  assign je_rd      = (state_q == READ);
  assign blk_start  = (state_q == READ) && (byte_cnt == 8'd0);
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign blk_idx    = idx_q;
  assign err        = err_q;
  assign enc_load   = rd_p1;

endmodule

// File: tb/tb_yuyv_block_sched.sv
// -----------------------------------------------------------------------------
// tb_yuyv_block_sched
//
// Randomized frames on a small image. Each block's read start is predicted
// from the block's arrival time, the earliest moment the scheduler can look
// for a new block, the drain delay, and the first cycle the encoder is free.
// The predictions are queued, and a monitor compares every blk_start and
// frame_done it observes against them. Directed sections then cover reset
// behaviour, IDLE filtering, pending overflow, reset mid-burst and the
// frame_rdy-while-busy error.
// -----------------------------------------------------------------------------
module tb_yuyv_block_sched;

  localparam int WIDTH  = 32;
  localparam int HEIGHT = 16;
  localparam int BB     = 24;
  localparam int DD     = 4;
  localparam int NBLK   = (WIDTH / 8) * (HEIGHT / 8);
  localparam int EBN    = 20000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_rdy = 1'b0;
  logic       blk_ready = 1'b0;
  logic       enc_busy = 1'b0;
  logic       img_req;
  logic       je_rd;
  logic       enc_load;
  logic       blk_start;
  logic [9:0] blk_idx;
  logic       frame_done;
  logic       busy;
  logic       err;

  yuyv_block_sched #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BLK_BYTES(BB), .DRAIN_DLY(DD)
  ) dut (
    .clk(clk), .reset(reset), .frame_rdy(frame_rdy), .img_req(img_req),
    .blk_ready(blk_ready), .enc_busy(enc_busy), .je_rd(je_rd),
    .enc_load(enc_load), .blk_start(blk_start), .blk_idx(blk_idx),
    .frame_done(frame_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int idx;
  } ev_t;

  ev_t exp_start[$];
  int  exp_done[$];
  int  rdy_q[$];
  bit  eb[0:EBN-1];
  bit  auto_eb = 1'b0;
  bit  sb_on = 1'b0;
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    frame_rdy = 1'b0;
    blk_ready = 1'b0;
    if (auto_eb && cyc < EBN) enc_busy = eb[cyc];
  endtask

  // Reference timing: a block read starts one cycle after the first cycle,
  // at least DD+1 cycles after max(arrival, scheduler ready), in which the
  // encoder is free. The scheduler is ready again two cycles after a burst.
  task automatic plan_frame(input int f, output int done_t);
    int s[NBLK];
    int w;
    int r;
    int c;
    ev_t e;
    w = f + 3;
    r = 0;
    for (int k = 0; k < NBLK; k++) begin
      if (k == 0) r = f + 1 + int'($urandom_range(0, 8));
      else        r = r + int'($urandom_range(1, 60));
      // keep at most three blocks outstanding
      if (k >= 3 && r < s[k-3]) r = s[k-3];
      rdy_q.push_back(r);
      c = ((r > w) ? r : w) + DD + 1;
      while (c < EBN - 1 && eb[c]) c++;
      s[k] = c + 1;
      e.t = c + 1;
      e.idx = k;
      exp_start.push_back(e);
      w = c + 1 + BB + 1;
    end
    done_t = w;
    exp_done.push_back(w);
  endtask

  // Monitor / scoreboard
  initial begin
    int  run;
    bit  prev_rd;
    ev_t ev;
    int  dt;
    run = 0;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_on) begin
        if (blk_start) begin
          if (exp_start.size() == 0) begin
            chk("blk_start_unexpected", 1, 0);
          end else begin
            ev = exp_start.pop_front();
            chk("start_cycle", cyc, ev.t);
            chk("start_idx", int'(blk_idx), ev.idx);
          end
        end
        if (je_rd && !prev_rd) chk("start_on_rise", int'(blk_start), 1);
        if (enc_load || prev_rd) chk("enc_load_lag", int'(enc_load), int'(prev_rd));
        if (je_rd) begin
          run++;
        end else if (run != 0) begin
          chk("burst_len", run, BB);
          run = 0;
        end
        if (frame_done) begin
          if (exp_done.size() == 0) begin
            chk("frame_done_unexpected", 1, 0);
          end else begin
            dt = exp_done.pop_front();
            chk("frame_done_cycle", cyc, dt);
          end
        end
        prev_rd = je_rd;
      end else begin
        run = 0;
        prev_rd = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int done_t;
    int t;
    int s0, s1, s2, s3;
    int i;
    int len;
    bit v;

    // busy pattern: random-length runs, roughly 40% busy
    i = 0;
    while (i < EBN) begin
      len = int'($urandom_range(1, 30));
      v = ($urandom_range(0, 9) < 4);
      for (int j = 0; j < len && i < EBN; j++) begin
        eb[i] = v;
        i++;
      end
    end

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_img_req", int'(img_req), 0);
    chk("rst_je_rd", int'(je_rd), 0);
    chk("rst_enc_load", int'(enc_load), 0);
    chk("rst_blk_start", int'(blk_start), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_blk_idx", int'(blk_idx), 0);
    chk("rst_err", int'(err), 0);

    // Randomized full frames
    auto_eb = 1'b1;
    sb_on = 1'b1;
    for (int fr = 0; fr < 3; fr++) begin
      step();
      f = cyc;
      plan_frame(f, done_t);
      frame_rdy = 1'b1;
      while (cyc < done_t + 3) begin
        step();
        if (rdy_q.size() > 0 && rdy_q[0] == cyc) begin
          void'(rdy_q.pop_front());
          blk_ready = 1'b1;
        end
        if (fr == 0 && cyc == f + 1) begin
          chk("req_c1", int'(img_req), 1);
          chk("busy_c1", int'(busy), 1);
        end
        if (fr == 0 && cyc == f + 2) chk("req_c2", int'(img_req), 1);
        if (fr == 0 && cyc == f + 3) chk("req_c3", int'(img_req), 0);
        if (cyc == done_t + 1) begin
          chk("busy_after_done", int'(busy), 0);
          chk("last_idx_hold", int'(blk_idx), NBLK - 1);
        end
      end
      chk("frame_err", int'(err), 0);
    end
    sb_on = 1'b0;
    auto_eb = 1'b0;
    enc_busy = 1'b0;
    chk("starts_left", exp_start.size(), 0);
    chk("dones_left", exp_done.size(), 0);

    // Inputs coincident with reset are ignored
    step();
    reset = 1'b1;
    frame_rdy = 1'b1;
    blk_ready = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_frame_busy", int'(busy), 0);
    chk("rst_frame_err", int'(err), 0);
    repeat (3) step();
    chk("rst_frame_idle", int'(busy), 0);

    // blk_ready in IDLE is not remembered
    step();
    blk_ready = 1'b1;
    step();
    frame_rdy = 1'b1;
    f = cyc;
    while (cyc < f + DD + 11) step();
    chk("idle_blk_ignored", int'(je_rd), 0);
    chk("idle_blk_busy", int'(busy), 1);

    // Latency, enc_load lag, then overflow of the pending count
    step();
    blk_ready = 1'b1;
    t = cyc;
    s0 = t + DD + 2;
    s1 = s0 + BB + DD + 3;
    s2 = s1 + BB + DD + 3;
    s3 = s2 + BB + DD + 3;
    while (cyc < s3 + BB + DD + 4) begin
      step();
      if (cyc == s0 + 3 || cyc == s0 + 8 || cyc == s0 + 13 || cyc == s0 + 18)
        blk_ready = 1'b1;
      if (cyc == s0 - 1) chk("lat_pre_rd", int'(je_rd), 0);
      if (cyc == s0) begin
        chk("lat_first_rd", int'(je_rd), 1);
        chk("lat_blk_start", int'(blk_start), 1);
        chk("lat_blk_idx", int'(blk_idx), 0);
        chk("lat_load_pre", int'(enc_load), 0);
      end
      if (cyc == s0 + 1) begin
        chk("lat_load", int'(enc_load), 1);
        chk("lat_start_once", int'(blk_start), 0);
      end
      if (cyc == s0 + 19) chk("ovf_err", int'(err), 1);
      if (cyc == s1) begin
        chk("pend_blk1", int'(blk_start), 1);
        chk("pend_idx1", int'(blk_idx), 1);
      end
      if (cyc == s2) begin
        chk("pend_blk2", int'(blk_start), 1);
        chk("pend_idx2", int'(blk_idx), 2);
      end
      if (cyc == s3) begin
        chk("pend_blk3", int'(blk_start), 1);
        chk("pend_idx3", int'(blk_idx), 3);
      end
      if (cyc == s3 + BB + DD + 3) chk("pend_sat_no4", int'(je_rd), 0);
    end

    // Reset in the middle of a burst
    step();
    blk_ready = 1'b1;
    t = cyc;
    while (cyc < t + DD + 2 + 12) step();
    chk("mid_rd_active", int'(je_rd), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_je_rd", int'(je_rd), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_idx", int'(blk_idx), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_load", int'(enc_load), 0);

    // frame_rdy while busy flags an error
    step();
    frame_rdy = 1'b1;
    step();
    chk("req_no_err", int'(err), 0);
    frame_rdy = 1'b1;
    step();
    chk("busy_frame_err", int'(err), 1);
    chk("busy_frame_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("err_cleared", int'(err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
